// File: rtl/vram_text_ctrl.sv
// rtl/vram_text_ctrl.sv - text-mode VRAM with cursor write engine and hardware scroll
// Optional cursor_hit output is enabled by defining VRAM_CURSOR_EN.
module vram_text_ctrl #(
  parameter int                COLS    = 64,
  parameter int                ROWS    = 32,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] FILL    = 8'h20,
  parameter bit                OUT_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DATA_W-1:0]        cmd_data,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic [$clog2(ROWS)-1:0]  scroll
`ifdef VRAM_CURSOR_EN
  ,
  output logic                     cursor_hit
`endif
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int CELLS = COLS * ROWS;
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);

  localparam logic [1:0] OP_PUT   = 2'b00;
  localparam logic [1:0] OP_NL    = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_CR    = 2'b11;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LCLR, ST_CLR} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [CW-1:0]     col_nxt;
  logic [RW-1:0]     row_nxt, scroll_nxt;
  logic [RW-1:0]     lclr_row, lclr_row_nxt;
  logic              line_adv;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RW-1:0]     cur_phys_row, rd_phys_row;
  logic [DATA_W-1:0] mem [CELLS];
  logic [DATA_W-1:0] rd_q;

  // Logical-to-physical row mapping wraps on RW-bit overflow.
  assign cur_phys_row = cur_row + scroll;
  assign rd_phys_row  = rd_row + scroll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      scroll   <= '0;
      lclr_row <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_col  <= col_nxt;
      cur_row  <= row_nxt;
      scroll   <= scroll_nxt;
      lclr_row <= lclr_row_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    col_nxt      = cur_col;
    row_nxt      = cur_row;
    scroll_nxt   = scroll;
    lclr_row_nxt = lclr_row;
    line_adv     = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = cnt;
    wr_data      = FILL;
    cmd_ready    = 1'b0;
    case (state)
      ST_INIT, ST_CLR: begin
        wr_en   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CELL_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          if (state == ST_CLR) begin
            col_nxt    = '0;
            row_nxt    = '0;
            scroll_nxt = '0;
          end
        end
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUT: begin
              wr_en   = 1'b1;
              wr_addr = {cur_phys_row, cur_col};
              wr_data = cmd_data;
              if (cur_col == COL_LAST) begin
                col_nxt  = '0;
                line_adv = 1'b1;
              end else begin
                col_nxt = cur_col + 1'b1;
              end
            end
            OP_NL: begin
              col_nxt  = '0;
              line_adv = 1'b1;
            end
            OP_CLEAR: begin
              state_nxt = ST_CLR;
              cnt_nxt   = '0;
            end
            OP_CR: col_nxt = '0;
          endcase
          // Bottom-row overflow: the old top physical row becomes the new bottom line.
          if (line_adv) begin
            if (cur_row == ROW_LAST) begin
              scroll_nxt   = scroll + 1'b1;
              lclr_row_nxt = scroll;
              state_nxt    = ST_LCLR;
              cnt_nxt      = '0;
            end else begin
              row_nxt = cur_row + 1'b1;
            end
          end
        end
      end
      ST_LCLR: begin
        wr_en   = 1'b1;
        wr_addr = {lclr_row, cnt[CW-1:0]};
        cnt_nxt = cnt + 1'b1;
        if (cnt[CW-1:0] == COL_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a same-cycle write to the same cell is seen on the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= mem[{rd_phys_row, rd_col}];
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_W-1:0] rd_q2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q2 <= '0;
        else        rd_q2 <= rd_q;
      end
      assign rd_data = rd_q2;
    end else begin : g_noreg
      assign rd_data = rd_q;
    end
  endgenerate

`ifdef VRAM_CURSOR_EN
  logic hit_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else        hit_q <= (rd_col == cur_col) && (rd_row == cur_row);
  end

  generate
    if (OUT_REG) begin : g_hreg
      logic hit_q2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_q2 <= 1'b0;
        else        hit_q2 <= hit_q;
      end
      assign cursor_hit = hit_q2;
    end else begin : g_nohreg
      assign cursor_hit = hit_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_vram_text_ctrl.sv
// tb/tb_vram_text_ctrl.sv - directed self-checking bench for vram_text_ctrl
module tb_vram_text_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [7:0] rd_data;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic [4:0] scroll;
`ifdef VRAM_CURSOR_EN
  logic       cursor_hit;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vram_text_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .scroll    (scroll)
`ifdef VRAM_CURSOR_EN
    ,
    .cursor_hit(cursor_hit)
`endif
  );

  task automatic read_cell(input logic [5:0] c, input logic [4:0] r, output logic [7:0] d);
    rd_col = c;
    rd_row = r;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic scan_all(output int errs);
    logic [7:0] d;
    errs = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) begin
        read_cell(6'(c), 5'(r), d);
        if (d !== 8'h20) errs++;
      end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    int n;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL cmd_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n, errs;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    total++; if (cur_col !== 6'd0 || cur_row !== 5'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    total++; if (scroll !== 5'd0) begin bad++; $display("FAIL rst_scroll: got %0d want 0", scroll); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    rst_n = 1'b1;
    count_busy(n);
    total++; if (n !== 2048) begin bad++; $display("FAIL init_busy: got %0d cycles want 2048", n); end
    scan_all(errs);
    total++; if (errs !== 0) begin bad++; $display("FAIL init_fill: %0d cells not 20, want 0", errs); end
  endtask

  task automatic test_put;
    logic [7:0] d;
    rd_col = 6'd0;
    rd_row = 5'd0;
    send_cmd(2'b00, 8'h41);
    total++; if (rd_data !== 8'h20) begin bad++; $display("FAIL read_first: got %h want 20", rd_data); end
    read_cell(6'd0, 5'd0, d);
    total++; if (d !== 8'h41) begin bad++; $display("FAIL put_data: got %h want 41", d); end
    total++; if (cur_col !== 6'd1 || cur_row !== 5'd0) begin bad++; $display("FAIL put_cursor: got (%0d,%0d) want (1,0)", cur_col, cur_row); end
`ifdef VRAM_CURSOR_EN
    read_cell(6'd1, 5'd0, d);
    total++; if (cursor_hit !== 1'b1) begin bad++; $display("FAIL cursor_hit_on: got %b want 1", cursor_hit); end
    read_cell(6'd0, 5'd0, d);
    total++; if (cursor_hit !== 1'b0) begin bad++; $display("FAIL cursor_hit_off: got %b want 0", cursor_hit); end
`endif
  endtask

  task automatic test_back_to_back;
    int acc;
    logic [7:0] d;
    send_cmd(2'b11, 8'h00);
    total++; if (cur_col !== 6'd0 || cur_row !== 5'd0) begin bad++; $display("FAIL cr_cursor: got (%0d,%0d) want (0,0)", cur_col, cur_row); end
    acc = 0;
    cmd_op = 2'b00;
    cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cmd_data = 8'(8'h80 + i);
      if (cmd_ready === 1'b1) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++; if (acc !== 64) begin bad++; $display("FAIL b2b_accepts: got %0d want 64", acc); end
    total++; if (cur_col !== 6'd0 || cur_row !== 5'd1) begin bad++; $display("FAIL b2b_cursor: got (%0d,%0d) want (0,1)", cur_col, cur_row); end
    read_cell(6'd5, 5'd0, d);
    total++; if (d !== 8'h85) begin bad++; $display("FAIL b2b_col5: got %h want 85", d); end
    read_cell(6'd63, 5'd0, d);
    total++; if (d !== 8'hBF) begin bad++; $display("FAIL b2b_col63: got %h want bf", d); end
  endtask

  task automatic test_scroll;
    int n, errs;
    logic [7:0] d;
    for (int r = 1; r < 32; r++)
      for (int c = 0; c < 64; c++)
        send_cmd(2'b00, 8'(r * 7 + c));
    count_busy(n);
    total++; if (n !== 64) begin bad++; $display("FAIL lclr_busy: got %0d want 64", n); end
    total++; if (scroll !== 5'd1) begin bad++; $display("FAIL scroll_one: got %0d want 1", scroll); end
    total++; if (cur_col !== 6'd0 || cur_row !== 5'd31) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,31)", cur_col, cur_row); end
    send_cmd(2'b00, 8'h5A);
    read_cell(6'd0, 5'd31, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL bottom_col0: got %h want 5a", d); end
    errs = 0;
    for (int c = 1; c < 64; c++) begin
      read_cell(6'(c), 5'd31, d);
      if (d !== 8'h20) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bottom_cleared: %0d cells not 20, want 0", errs); end
    errs = 0;
    for (int c = 0; c < 64; c++) begin
      read_cell(6'(c), 5'd0, d);
      if (d !== 8'(7 + c)) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL top_is_row1: %0d cells differ, want 0", errs); end
    read_cell(6'd3, 5'd30, d);
    total++; if (d !== 8'(31 * 7 + 3)) begin bad++; $display("FAIL row30_is_row31: got %h want dc", d); end
  endtask

  task automatic test_clear;
    int n, errs;
    logic [7:0] d;
    send_cmd(2'b11, 8'hFF);
    read_cell(6'd0, 5'd31, d);
    total++; if (d !== 8'h5A || cur_col !== 6'd0) begin bad++; $display("FAIL cr_nowrite: got %h col %0d want 5a col 0", d, cur_col); end
    send_cmd(2'b01, 8'h00);
    count_busy(n);
    total++; if (n !== 64 || scroll !== 5'd2) begin bad++; $display("FAIL nl_scroll: got busy %0d scroll %0d want 64 2", n, scroll); end
    read_cell(6'd0, 5'd30, d);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL nl_shift: got %h want 5a", d); end
    send_cmd(2'b10, 8'h00);
    total++; if (scroll !== 5'd2) begin bad++; $display("FAIL clr_scroll_hold: got %0d want 2", scroll); end
    count_busy(n);
    total++; if (n !== 2048) begin bad++; $display("FAIL clr_busy: got %0d want 2048", n); end
    total++; if (scroll !== 5'd0 || cur_col !== 6'd0 || cur_row !== 5'd0) begin bad++; $display("FAIL clr_home: got scroll %0d (%0d,%0d) want 0 (0,0)", scroll, cur_col, cur_row); end
    scan_all(errs);
    total++; if (errs !== 0) begin bad++; $display("FAIL clr_fill: %0d cells not 20, want 0", errs); end
  endtask

  task automatic test_reset_mid_lclr;
    int n, errs;
    for (int i = 0; i < 31; i++) send_cmd(2'b01, 8'h00);
    send_cmd(2'b00, 8'h77);
    send_cmd(2'b01, 8'h00);
    rd_col = 6'd0;
    rd_row = 5'd0;
    repeat (10) @(negedge clk);
    total++; if (cmd_ready !== 1'b0 || scroll !== 5'd1) begin bad++; $display("FAIL mid_lclr: ready %b scroll %0d want 0 1", cmd_ready, scroll); end
    rst_n = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b0 || scroll !== 5'd0 || cur_col !== 6'd0 || cur_row !== 5'd0 || rd_data !== 8'h00) begin
      bad++; $display("FAIL async_rst: ready %b scroll %0d (%0d,%0d) rd %h want 0 0 (0,0) 00", cmd_ready, scroll, cur_col, cur_row, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    total++; if (n !== 2048) begin bad++; $display("FAIL reinit_busy: got %0d want 2048", n); end
    scan_all(errs);
    total++; if (errs !== 0) begin bad++; $display("FAIL reinit_fill: %0d cells not 20, want 0", errs); end
  endtask

  initial begin
    test_reset;
    test_put;
    test_back_to_back;
    test_scroll;
    test_clear;
    test_reset_mid_lclr;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
